hex_rate_counter: RTL and testbench

HEX_RATE_COUNTER -- requirements
Module: hex_rate_counter

---
 rtl/hex_rate_counter_pkg.sv | 32 +++
 rtl/hex_rate_counter_rate_divider.sv | 47 ++++
 rtl/hex_rate_counter.sv | 52 +++++
 tb/tb_hex_rate_counter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/hex_rate_counter_pkg.sv
// Shared definitions for the hex rate counter.
//   spd_e       : speed select encodings
//   div_width() : bit width of the rate divider for a given clock rate
//   period()    : divider period in clock cycles for a speed setting
package hex_rate_counter_pkg;

  typedef enum logic [1:0] {
    SPD_FULL    = 2'b00,  // advance every cycle
    SPD_1HZ     = 2'b01,  // every CLK_HZ cycles
    SPD_HALF    = 2'b10,  // every 2*CLK_HZ cycles
    SPD_QUARTER = 2'b11   // every 4*CLK_HZ cycles
  } spd_e;

  localparam int unsigned DEFAULT_CLK_HZ = 50_000_000;

  // Enough bits to hold 4*clk_hz-1, the longest reload value.
  function automatic int div_width(input longint unsigned clk_hz);
    return $clog2(4 * clk_hz);
  endfunction

  localparam int DIV_W_DEFAULT = div_width(DEFAULT_CLK_HZ);

  function automatic longint unsigned period(input spd_e s, input longint unsigned clk_hz);
    case (s)
      SPD_FULL: return 64'd1;
      SPD_1HZ:  return clk_hz;
      SPD_HALF: return 2 * clk_hz;
      default:  return 4 * clk_hz;
    endcase
  endfunction

endpackage

// File: rtl/hex_rate_counter_rate_divider.sv
// Rate divider: down-counter that pulses advance when it reaches 0 and
// reloads period-1 in the same cycle.
//   clock   : system clock
//   reset   : async active-high; loads period(speed)-1
//   enable  : lets the divider count; low freezes it
//   speed   : period select (spd_e encoding)
//   clear   : reload divider, suppress advance (parallel load)
//   advance : combinational one-cycle strobe to the hex counter
module rate_divider
  import hex_rate_counter_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] speed,
  input  logic       clear,
  output logic       advance
);

  localparam int DIV_W = div_width(CLK_HZ);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] reload;
  logic [1:0]       spd_q;
  logic             spd_chg;

  assign reload  = DIV_W'(period(spd_e'(speed), CLK_HZ) - 64'd1);
  // A new speed restarts the interval; the old partial period is dropped.
  assign spd_chg = (speed != spd_q);
  assign advance = enable && !clear && !spd_chg && (cnt == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt   <= reload;
      spd_q <= speed;
    end else begin
      spd_q <= speed;
      if (clear || spd_chg)
        cnt <= reload;
      else if (enable)
        cnt <= (cnt == '0) ? reload : cnt - DIV_W'(1);
    end
  end

endmodule

// File: rtl/hex_rate_counter.sv
// Hex digit counter stepping at a selectable rate.
//   CLOCK_50 : system clock (rising edge)
//   reset    : async active-high; count=0, tick=0, divider reloaded
//   enable   : allows divider and counter to advance
//   speed    : 00 every cycle, 01 CLK_HZ, 10 2*CLK_HZ, 11 4*CLK_HZ cycles
//   up       : 1 increment, 0 decrement (mod 16)
//   load     : sync parallel load of load_val; wins over advance
//   count    : registered hex digit
//   tick     : registered pulse, high in cycles count took an advance
module hex_rate_counter
  import hex_rate_counter_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] speed,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] count,
  output logic       tick
);

  logic advance;

  rate_divider #(.CLK_HZ(CLK_HZ)) u_div (
    .clock   (CLOCK_50),
    .reset   (reset),
    .enable  (enable),
    .speed   (speed),
    .clear   (load),
    .advance (advance)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      count <= 4'h0;
      tick  <= 1'b0;
    end else if (load) begin
      count <= load_val;
      tick  <= 1'b0;
    end else if (advance) begin
      count <= up ? count + 4'h1 : count - 4'h1;
      tick  <= 1'b1;
    end else begin
      tick  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hex_rate_counter.sv
// Directed bench for hex_rate_counter with CLK_HZ=4
// (periods: 00->1, 01->4, 10->8, 11->16 cycles).
module tb_hex_rate_counter;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b0;
  logic       enable   = 1'b0;
  logic [1:0] speed    = 2'b01;
  logic       up       = 1'b1;
  logic       load     = 1'b0;
  logic [3:0] load_val = 4'h0;
  logic [3:0] count;
  logic       tick;

  int total = 0;
  int bad   = 0;

  hex_rate_counter #(.CLK_HZ(4)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .enable   (enable),
    .speed    (speed),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tick     (tick)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Advance n rising edges, then settle 1ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  initial begin
    // Asynchronous reset before any clock edge.
    #1 reset = 1'b1;
    #2;
    check("rst_count", count, 4'h0);
    check("rst_tick", {3'b0, tick}, 4'h0);
    step(2);
    reset = 1'b0;

    // Load 7, then reset mid-interval while counting at speed 01.
    load = 1'b1; load_val = 4'h7;
    step(1);
    load = 1'b0;
    check("load7", count, 4'h7);
    enable = 1'b1;
    step(2);
    check("mid_count7", count, 4'h7);
    #2 reset = 1'b1;
    #1;
    check("async_rst_count", count, 4'h0);
    check("async_rst_tick", {3'b0, tick}, 4'h0);
    step(1);
    reset = 1'b0;
    step(3);
    check("post_rst_wait", count, 4'h0);
    check("post_rst_wait_tick", {3'b0, tick}, 4'h0);
    step(1);
    check("post_rst_first", count, 4'h1);
    check("post_rst_tick", {3'b0, tick}, 4'h1);
    step(1);
    check("tick_one_cycle", {3'b0, tick}, 4'h0);

    // Up-count wrap E -> F -> 0 at 4-cycle spacing.
    load = 1'b1; load_val = 4'hE;
    step(1);
    load = 1'b0;
    check("loadE", count, 4'hE);
    step(3);
    check("wrap_holdE", count, 4'hE);
    step(1);
    check("wrap_F", count, 4'hF);
    check("wrap_F_tick", {3'b0, tick}, 4'h1);
    step(3);
    check("wrap_holdF", count, 4'hF);
    check("wrap_holdF_tick", {3'b0, tick}, 4'h0);
    step(1);
    check("wrap_0", count, 4'h0);
    check("wrap_0_tick", {3'b0, tick}, 4'h1);

    // Down-count at speed 11: the change edge reloads (no step),
    // then F lands 16 cycles later.
    speed = 2'b11; up = 1'b0;
    step(1);
    check("spd11_reload", count, 4'h0);
    check("spd11_reload_tick", {3'b0, tick}, 4'h0);
    step(15);
    check("spd11_hold", count, 4'h0);
    step(1);
    check("down_F", count, 4'hF);
    check("down_F_tick", {3'b0, tick}, 4'h1);
    // Speed 10: reload edge, then E 8 cycles later.
    speed = 2'b10;
    step(1);
    check("spd10_reload", count, 4'hF);
    step(7);
    check("spd10_hold", count, 4'hF);
    step(1);
    check("down_E", count, 4'hE);
    check("down_E_tick", {3'b0, tick}, 4'h1);

    // Load lands on the same edge as an advance: load wins, no tick.
    speed = 2'b01;
    step(1);
    step(3);
    check("pre_load_hold", count, 4'hE);
    load = 1'b1; load_val = 4'hA;
    step(1);
    load = 1'b0;
    check("loadA_over_adv", count, 4'hA);
    check("loadA_tick", {3'b0, tick}, 4'h0);
    step(3);
    check("loadA_full_period", count, 4'hA);
    step(1);
    check("after_load_dec", count, 4'h9);
    check("after_load_tick", {3'b0, tick}, 4'h1);
    // Direction change applies to the next advance only.
    up = 1'b1;
    step(3);
    check("up_chg_hold", count, 4'h9);
    step(1);
    check("up_chg_inc", count, 4'hA);

    // Freeze with one divider cycle left (divider 3 -> 2 -> 1).
    step(2);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("freeze_count", count, 4'hA);
      check("freeze_tick", {3'b0, tick}, 4'h0);
    end
    enable = 1'b1;
    step(1);
    check("resume_hold", count, 4'hA);
    step(1);
    check("resume_B", count, 4'hB);
    check("resume_tick", {3'b0, tick}, 4'h1);

    // Full speed from 0: steps every cycle 1..F,0..3, tick stays high.
    load = 1'b1; load_val = 4'h0; speed = 2'b00;
    step(1);
    load = 1'b0;
    check("full_load0", count, 4'h0);
    for (int i = 1; i < 20; i++) begin
      step(1);
      check("full_count", count, 4'(i));
      check("full_tick", {3'b0, tick}, 4'h1);
    end
    enable = 1'b0;
    step(1);
    check("full_stop_tick", {3'b0, tick}, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
